// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer and the datapath ALU it borrows.
// Holds the ALU operation encodings, the sequencer state encoding and step-count limits.
// No logic of its own; imported by alu_mul_sequencer.
package alu_mul_sequencer_pkg;

  // ALU operation encodings, shared with the datapath ALU.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SR  = 4'b0110;
  localparam logic [3:0] ALU_SL  = 4'b0111;

  // Command driven while the sequencer does not own the ALU. It happens to
  // share its encoding with ADD; operands are zero so the result is inert.
  localparam logic [3:0] ALU_IDLE_OP = 4'b0000;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Step counter: 6 bits, last legal step index is 31 (32 steps total).
  localparam int unsigned   COUNT_W   = 6;
  localparam logic [5:0]    LAST_STEP = 6'd31;

  // A RUN step is the last one when no set bits remain in the multiplier
  // after this step's shift, or when all 32 bit positions have been consumed.
  function automatic logic step_is_last(input logic       rest_zero,
                                        input logic [5:0] count);
    return rest_zero || (count == LAST_STEP);
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller: low DATA_WIDTH bits of A*B using the shared ALU's ADD.
// Latency: n+1 cycles from accepted start to done_o (n = multiplier bit length, 0..32), max 33.
// Backpressure: none; start_i is only sampled in IDLE and ignored (not queued) while busy_o is high.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start_i             - request pulse, accepted only in IDLE
//   multiplicand_i      - operand A, captured with the accepted start
//   multiplier_i        - operand B, captured with the accepted start
//   alu_result_i        - combinational result of the ALU for the command driven below
//   alu_operation_o     - ALU operation (ADD in RUN, neutral otherwise)
//   alu_a_o, alu_b_o    - ALU operands (accumulator / shifted multiplicand in RUN, 0 otherwise)
//   busy_o              - high in RUN and DONE; selects this block onto the ALU buses
//   done_o              - one-cycle completion pulse
//   product_o           - registered low product, held between operations
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] multiplicand_i,
  input  logic [DATA_WIDTH-1:0] multiplier_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic [3:0]            alu_operation_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [COUNT_W-1:0]    count;
  logic [DATA_WIDTH-1:0] product;

  logic                  in_run;
  logic [DATA_WIDTH-1:0] mplier_shr;
  logic                  last_step;

  assign in_run     = (state == ST_RUN);
  assign mplier_shr = mplier >> 1;
  assign last_step  = step_is_last(mplier_shr == '0, count);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          // A zero multiplier has bit length 0: skip RUN entirely.
          state_nxt = (multiplier_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            acc    <= '0;
            mcand  <= multiplicand_i;
            mplier <= multiplier_i;
            count  <= '0;
          end
        end
        ST_RUN: begin
          // The ALU is computing acc + mcand this cycle; only keep it when
          // the current multiplier bit asks for this partial product.
          if (mplier[0]) begin
            acc <= alu_result_i;
          end
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          count  <= count + 6'd1;
        end
        ST_DONE: begin
          product <= acc;
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs. Outside RUN the ALU command is forced neutral so a stale
  // accumulator never leaks onto the shared operand buses.
  // ------------------------------------------------------------------
  assign alu_operation_o = in_run ? ALU_ADD : ALU_IDLE_OP;
  assign alu_a_o         = in_run ? acc     : '0;
  assign alu_b_o         = in_run ? mcand   : '0;
  assign busy_o          = (state == ST_RUN) || (state == ST_DONE);
  assign done_o          = (state == ST_DONE);
  assign product_o       = product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] multiplicand_i;
  logic [31:0] multiplier_i;
  logic [31:0] alu_result;
  logic [3:0]  alu_operation;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic        done_d = 1'b0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared single-cycle ALU. Only ADD is
  // meaningful here; any other opcode yields a poison value.
  assign alu_result = (alu_operation == 4'b0000) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .multiplicand_i  (multiplicand_i),
    .multiplier_i    (multiplier_i),
    .alu_result_i    (alu_result),
    .alu_operation_o (alu_operation),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .busy_o          (busy),
    .done_o          (done),
    .product_o       (product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int bit_len(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Scoreboard: product_o must equal the oldest expected value in the
  // cycle after each done pulse.
  always @(negedge clk) begin
    if (done_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
    done_d <= done;
  end

  // Called #1 after the accepting edge E0. Negedge index 0 is the cycle
  // right after E0; done must appear at index n, busy for n+1 cycles.
  task automatic wait_done(input int n, input string tag);
    int got   = -1;
    int bcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && !done) check({tag, "_alu_op"}, {28'd0, alu_operation}, 32'd0);
      if (done) begin
        got = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(got), 32'(n));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(n + 1));
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i        = 1'b1;
    multiplicand_i = a;
    multiplier_i   = b;
    exp_q.push_back(a * b);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(a, b);
    start_i = 1'b0;
    wait_done(bit_len(b), tag);
    @(negedge clk);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_alu_a_idle"}, alu_a, 32'd0);
    check({tag, "_alu_b_idle"}, alu_b, 32'd0);
  endtask

  initial begin
    int dcnt;
    reset          = 1'b1;
    start_i        = 1'b0;
    multiplicand_i = '0;
    multiplier_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_alu_op",  {28'd0, alu_operation}, 32'd0);
    check("rst_alu_a",   alu_a, 32'd0);
    check("rst_alu_b",   alu_b, 32'd0);
    reset = 1'b0;

    run_op(32'd6, 32'd7, "6x7");
    check("6x7_held", product, 32'd42);
    run_op(32'h12345678, 32'd0, "mplier0");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "all_ones");
    run_op(32'hFFFFFFFD, 32'd5, "neg3x5");
    repeat (3) @(negedge clk);
    check("product_hold", product, 32'hFFFFFFF1);

    // start_i held high with operands changed mid-run: the running
    // operation is unaffected; the next one is taken only from IDLE.
    start_op(32'd6, 32'd7);
    multiplicand_i = 32'd99;
    multiplier_i   = 32'hFFFF;
    wait_done(3, "hold");
    multiplicand_i = 32'd2;
    multiplier_i   = 32'd3;
    exp_q.push_back(32'd6);
    @(negedge clk);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(2, "hold_second");

    for (int k = 0; k < 6; k++) begin
      run_op($urandom, $urandom >> $urandom_range(0, 31), "rand");
    end

    // Reset in the second RUN cycle of 3 x 0xF0.
    @(negedge clk);
    start_i        = 1'b1;
    multiplicand_i = 32'd3;
    multiplier_i   = 32'hF0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",    {31'd0, busy}, 32'd0);
    check("rst_mid_done",    {31'd0, done}, 32'd0);
    check("rst_mid_product", product, 32'd0);
    check("rst_mid_alu_op",  {28'd0, alu_operation}, 32'd0);
    check("rst_mid_alu_a",   alu_a, 32'd0);
    check("rst_mid_alu_b",   alu_b, 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("rst_mid_no_done", 32'(dcnt), 32'd0);

    run_op(32'd3, 32'hF0, "after_rst");
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle controller that computes the low 32 bits of a 32×32 product using the shared single-cycle ALU's ADD operation, one shift-and-add step per clock. It sits beside the datapath ALU. While `busy_o` is high, the top-level mux hands the ALU operand and operation buses to this block. When idle, the block drives a neutral ALU command.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must match the ALU width.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start_i`  in  1: request pulse; sampled only in IDLE.
- `multiplicand_i`  in  32: operand A; captured on the accepted `start_i`.
- `multiplier_i`  in  32: operand B; captured on the accepted `start_i`.
- `alu_result_i`  in  32: ALU `ALU_Result_o`, combinational from the driven command.
- `alu_operation_o`  out  4: ALU operation code; ADD (4'b0000) in RUN, 4'b0000 otherwise.
- `alu_a_o`  out  32: ALU operand A; accumulator in RUN, 0 otherwise.
- `alu_b_o`  out  32: ALU operand B; shifted multiplicand in RUN, 0 otherwise.
- `busy_o`  out  1: high in RUN and DONE; top-level ALU mux select.
- `done_o`  out  1: one-cycle pulse in DONE.
- `product_o`  out  32: registered low product, held until the next accepted start.

## Operation
- Internal registers:
  - `acc` (32 bits)
  - `mcand` (32 bits)
  - `mplier` (32 bits)
  - `count` (6 bits)
  - `state`
- States are IDLE, RUN and DONE.
- **IDLE:**
  - When `start_i` is high, set `acc`=0, `mcand`=`multiplicand_i`, `mplier`=`multiplier_i` and `count`=0.
  - Go to RUN if `multiplier_i`≠0, otherwise go to DONE.
  - When `start_i` is low, stay in IDLE.
- **RUN (one step per cycle):**
  - If `mplier[0]`, set `acc` to `alu_result_i` (acc + mcand). Otherwise `acc` holds.
  - Set `mcand` to `mcand<<1`, `mplier` to `mplier>>1` (logical shift), and `count` to `count`+1.
  - Go to DONE when (`mplier>>1`)==0 or `count`==31. Otherwise stay in RUN.
- **DONE:**
  - `done_o`=1 and `product_o` is loaded from `acc`.
  - Unconditionally go to IDLE.
- Arithmetic wraps modulo 2^32; carries out of bit 31 and bits of `mcand` shifted past bit 31 are discarded.
- The low 32 bits are identical for signed and unsigned operands, so no sign handling is performed.
- `start_i` in RUN or DONE is ignored; it is not queued.
- The ALU `Zero_o` output is not used.

## Timing
- **Reset values:**
  - `state`=IDLE, `busy_o`=0, `done_o`=0, `product_o`=0.
  - `alu_operation_o`=0, `alu_a_o`=0, `alu_b_o`=0.
  - All internal registers are 0.
- **Latency:**
  - Let n be the bit length of the multiplier, i.e. the index of the highest set bit + 1, from 0 to 32.
  - If `start_i` is accepted at edge E0, the block spends n RUN cycles and `done_o` is high in the cycle after edge E0+n.
  - When multiplier=0 (n=0), `done_o` is high in the cycle immediately after E0.
  - The maximum latency is 33 cycles.
- `busy_o` rises in the cycle after E0 and falls in the cycle after DONE.
- The earliest next start is accepted at the edge that ends the DONE cycle plus one, i.e. in the IDLE cycle.
- `product_o` updates at the edge leaving DONE and is stable from the cycle after `done_o`.
- **Reset mid-operation:** reset in RUN or DONE returns the block to IDLE on that edge. The pending product is discarded, `done_o` does not pulse, and `product_o`=0.
- Reset and `start_i` high on the same edge: reset wins.

## Structure
- **Shared package/header:**
  - ALU operation encodings: ADD=4'b0000, SUB=4'b0001, OR=4'b0011, LUI=4'b0101, SR=4'b0110, SL=4'b0111.
  - The sequencer state encoding.
- **Top level:** the ALU operand/operation mux is selected by `busy_o`.
- **Sub-modules:** none. This is a single module with one state register block and one datapath register block.

## Test plan
- `start_i` with A=6, B=7: n=3; `done_o` in the cycle after E0+3; `product_o`=42; 4 cycles of `busy_o`.
- A=0x12345678, B=0: no RUN cycles; `done_o` in the cycle after E0; `product_o`=0.
- A=0xFFFFFFFF, B=0xFFFFFFFF: 32 RUN cycles; `product_o`=0x00000001; the ALU sees ADD on every RUN cycle.
- A=0xFFFFFFFD (−3), B=5: `product_o`=0xFFFFFFF1 (−15); 3 RUN cycles.
- `start_i` held high throughout the A=6, B=7 operation with new operands applied mid-run: result is still 42; a second operation starts only from IDLE.
- Reset asserted during the 2nd RUN cycle of A=3, B=0xF0:
  - State returns to IDLE on that edge.
  - `busy_o`=0, `done_o` never pulses, `product_o`=0.
  - ALU outputs are 0 on the next cycle.
